controller_poller: RTL

- Parametrised successor to the fixed two-pad serial controller interface.
- Polls NUM_CONTROLLERS NES-style shift-register pads in parallel over one shared latch/clock pair, with a configurable button count and shift rate.
- Publishes each poll atomically as active-high button state, plus sticky "newly pressed" flags for the CPU-visible register block.
- Polls are started by a one-cycle start pulse (e.g. vblank) or run back-to-back in auto mode.

---
 rtl/controller_poller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/controller_poller.sv
// Polls NES-style shift-register pads in parallel over a shared latch/clock.
// Publishes active-high button state and sticky press flags atomically.
module controller_poller #(
    parameter int NUM_CONTROLLERS = 2,
    parameter int BUTTONS         = 8,
    parameter int CLK_DIV         = 4,
    parameter int AUTO_POLL       = 0
) (
    input  logic                               clk_12_5875,
    input  logic                               rst_B,
    input  logic                               start,
    input  logic                               clear_pressed,
    input  logic [NUM_CONTROLLERS-1:0]         controller_data_in_B,
    output logic                               controller_clk,
    output logic                               controller_latch,
    output logic [NUM_CONTROLLERS*BUTTONS-1:0] buttons_out,
    output logic [NUM_CONTROLLERS*BUTTONS-1:0] pressed_out,
    output logic                               busy,
    output logic                               poll_done
);

    localparam int NB = NUM_CONTROLLERS * BUTTONS;
    localparam int CW = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam int KW = $clog2(BUTTONS);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] k_q, k_d;
    logic [NUM_CONTROLLERS-1:0][BUTTONS-1:0] shift_q, shift_d;
    logic [NB-1:0] buttons_q, buttons_d;
    logic [NB-1:0] pressed_q, pressed_d;
    logic [NB-1:0] fresh;
    logic [KW-1:0] bidx;
    logic latch_q, sclk_q, busy_q, done_q;
    logic last_latch, last_half;

    assign last_latch = (cnt_q == CW'(2 * CLK_DIV - 1));
    assign last_half  = (cnt_q == CW'(CLK_DIV - 1));
    assign fresh      = ~shift_q;

    // Next-state, counters, shift capture and published-state update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        shift_d   = shift_q;
        buttons_d = buttons_q;
        pressed_d = clear_pressed ? '0 : pressed_q;
        bidx      = KW'(BUTTONS - 1) - k_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                k_d   = '0;
                if (AUTO_POLL != 0 || start) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                if (last_latch) begin
                    cnt_d   = '0;
                    state_d = SHIFT_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT_LO: begin
                if (last_half) begin
                    cnt_d = '0;
                    for (int c = 0; c < NUM_CONTROLLERS; c++) begin
                        shift_d[c][bidx] = controller_data_in_B[c];
                    end
                    if (k_q == KW'(BUTTONS - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT_HI;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (last_half) begin
                    cnt_d   = '0;
                    k_d     = k_q + 1'b1;
                    state_d = SHIFT_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                cnt_d     = '0;
                k_d       = '0;
                // clear (if any) is already applied; fresh edges survive it
                pressed_d = pressed_d | (fresh & ~buttons_q);
                buttons_d = fresh;
                state_d   = (AUTO_POLL != 0) ? LATCH : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered pad/status outputs
    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            k_q       <= '0;
            shift_q   <= '0;
            buttons_q <= '0;
            pressed_q <= '0;
            latch_q   <= 1'b0;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            shift_q   <= shift_d;
            buttons_q <= buttons_d;
            pressed_q <= pressed_d;
            latch_q   <= (state_d == LATCH);
            sclk_q    <= (state_d == SHIFT_HI);
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
        end
    end

    assign controller_latch = latch_q;
    assign controller_clk   = sclk_q;
    assign busy             = busy_q;
    assign poll_done        = done_q;
    assign buttons_out      = buttons_q;
    assign pressed_out      = pressed_q;

endmodule
